// File: rtl/uart_tx_buffer_if.sv
// CPU-side bus for the buffered UART transmitter.
// Carries the write strobe and byte, the overflow clear, and the queue status.
interface uart_tx_buffer_if #(
    parameter int AW = 4
);
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          clr_ovf;
    logic          busy;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;

    modport master (
        output wr_en, wr_data, clr_ovf,
        input  busy, full, empty, count, overflow
    );

    modport slave (
        input  wr_en, wr_data, clr_ovf,
        output busy, full, empty, count, overflow
    );
endinterface

// File: rtl/uart_tx_buffer.sv
// Buffered 8N1 UART transmitter: CPU bytes go into a FIFO and are serialised
// back-to-back with a private baud counter; tx is registered.
module uart_tx_buffer #(
    parameter int CLKS_PER_BIT = 234,
    parameter int DEPTH        = 16,
    parameter int AW           = 4
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_buffer_if.slave   bus,
    output logic              tx
);
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic            ovf_q, ovf_d;
    logic [AW:0]     count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]      mem_q [DEPTH];

    logic wr_acc, pop, baud_end;

    assign wr_acc   = bus.wr_en && !full_q;
    assign baud_end = (baud_q == BW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (!empty_q) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        // Shift down so the next bit is always at [0] after the update.
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (!empty_q) begin
                        // Chain straight into the next start bit, no idle gap.
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_acc, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == (AW+1)'(DEPTH));
        empty_d = (count_d == '0);
        // A dropped write outranks a same-cycle clear.
        if (bus.wr_en && full_q) ovf_d = 1'b1;
        else if (bus.clr_ovf)    ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && wr_acc) mem_q[wr_ptr_q] <= bus.wr_data;
    end

    assign tx           = tx_q;
    assign bus.busy     = busy_q;
    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_uart_tx_buffer.sv
// Bench for uart_tx_buffer: directed writes feed a byte scoreboard; a line
// receiver decodes tx frames and checks them against the queue.
module tb_uart_tx_buffer;
    localparam int C  = 4;
    localparam int D  = 16;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tx;

    uart_tx_buffer_if #(.AW(AW)) bus ();

    uart_tx_buffer #(.CLKS_PER_BIT(C), .DEPTH(D), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .tx  (tx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count busy cycles until busy falls, bounded.
    task automatic wait_idle(output int n, input int bound);
        int  t;
        bit  seen;
        n = 0; t = 0; seen = 0;
        while (t < bound) begin
            @(negedge clk);
            t++;
            if (bus.busy) begin
                n++;
                seen = 1;
            end else if (seen) begin
                break;
            end
        end
        if (t >= bound) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout actual=%0d expected=<%0d", t, bound);
        end
    endtask

    // Line receiver: samples mid-bit at the negedge.
    initial begin
        bit         rx_act;
        int         rx_cnt;
        logic [7:0] rx_byte;
        logic [7:0] e;
        rx_act = 0; rx_cnt = 0; rx_byte = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                rx_act = 0;
            end else if (!rx_act) begin
                if (tx === 1'b0) begin
                    rx_act = 1;
                    rx_cnt = 0;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt == C/2) chk("start_bit", tx, 1'b0);
                if (rx_cnt >= C + C/2 && rx_cnt < 9*C && ((rx_cnt - C/2) % C) == 0)
                    rx_byte[(rx_cnt - C - C/2) / C] = tx;
                if (rx_cnt == 9*C + C/2) begin
                    chk("stop_bit", tx, 1'b1);
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame actual=%0h expected=none", rx_byte);
                    end else begin
                        e = sb.pop_front();
                        chk("rx_byte", rx_byte, e);
                    end
                    rx_act = 0;
                end
            end
        end
    end

    initial begin
        int n;
        int i;
        int cyc;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.clr_ovf = 1'b0;

        // Reset
        rst = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_empty", bus.empty, 1'b1);
        chk("rst_full", bus.full, 1'b0);
        chk("rst_count", bus.count, 0);
        chk("rst_ovf", bus.overflow, 1'b0);
        rst = 1'b1;
        step();

        // Single byte 0x41
        bus.wr_en = 1'b1; bus.wr_data = 8'h41; sb.push_back(8'h41);
        step();
        bus.wr_en = 1'b0;
        @(negedge clk);
        chk("single_count", bus.count, 1);
        chk("single_tx_idle", tx, 1'b1);
        wait_idle(n, 200);
        chk("single_busy_cycles", n, 40);
        chk("single_empty", bus.empty, 1'b1);

        // Back-to-back 0x55, 0xA3
        step();
        bus.wr_en = 1'b1; bus.wr_data = 8'h55; sb.push_back(8'h55);
        step();
        bus.wr_data = 8'hA3; sb.push_back(8'hA3);
        step();
        bus.wr_en = 1'b0;
        @(negedge clk);
        chk("b2b_count", bus.count, 1);
        chk("b2b_busy", bus.busy, 1'b1);
        wait_idle(n, 400);
        chk("b2b_busy_cycles", n + 1, 80);

        // Overflow: 18 writes, 18th dropped
        step();
        for (int k = 0; k < 18; k++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'(k);
            if (k <= 16) sb.push_back(8'(k));
            step();
        end
        bus.wr_en = 1'b0;
        @(negedge clk);
        chk("ovf_full", bus.full, 1'b1);
        chk("ovf_count", bus.count, 16);
        chk("ovf_flag", bus.overflow, 1'b1);
        bus.clr_ovf = 1'b1;
        step();
        bus.clr_ovf = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", bus.overflow, 1'b0);
        bus.wr_en = 1'b1; bus.wr_data = 8'hEE; bus.clr_ovf = 1'b1;
        step();
        bus.wr_en = 1'b0; bus.clr_ovf = 1'b0;
        @(negedge clk);
        chk("ovf_set_wins", bus.overflow, 1'b1);
        chk("ovf_count_kept", bus.count, 16);
        bus.clr_ovf = 1'b1;
        step();
        bus.clr_ovf = 1'b0;
        @(negedge clk);
        chk("ovf_cleared2", bus.overflow, 1'b0);
        wait_idle(n, 2000);
        chk("ovf_empty_end", bus.empty, 1'b1);

        // Wrap: 40 bytes written whenever not full
        step();
        i = 0; cyc = 0;
        while (i < 40 && cyc < 3000) begin
            if (!bus.full) begin
                bus.wr_en = 1'b1; bus.wr_data = 8'(i);
                sb.push_back(8'(i));
                i++;
            end else begin
                bus.wr_en = 1'b0;
            end
            step();
            cyc++;
        end
        bus.wr_en = 1'b0;
        chk("wrap_written", i, 40);
        wait_idle(n, 3000);
        chk("wrap_ovf", bus.overflow, 1'b0);
        chk("wrap_empty", bus.empty, 1'b1);
        chk("wrap_busy", bus.busy, 1'b0);
        chk("wrap_sb_drained", sb.size(), 0);

        // Reset mid-frame during data bit 3 with 3 queued
        step();
        bus.wr_en = 1'b1; bus.wr_data = 8'h11; sb.push_back(8'h11);
        step();
        bus.wr_data = 8'h22; sb.push_back(8'h22);
        step();
        bus.wr_data = 8'h33; sb.push_back(8'h33);
        step();
        bus.wr_data = 8'h44; sb.push_back(8'h44);
        step();
        bus.wr_en = 1'b0;
        repeat (15) step();
        @(negedge clk);
        chk("midrst_count_before", bus.count, 3);
        rst = 1'b0;
        sb.delete();
        step();
        @(negedge clk);
        chk("midrst_tx", tx, 1'b1);
        chk("midrst_count", bus.count, 0);
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_empty", bus.empty, 1'b1);
        rst = 1'b1;
        repeat (3) step();
        bus.wr_en = 1'b1; bus.wr_data = 8'h5A; sb.push_back(8'h5A);
        step();
        bus.wr_en = 1'b0;
        wait_idle(n, 200);
        chk("postrst_busy_cycles", n, 40);

        repeat (5) step();
        chk("final_sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
